// File: rtl/zle_px.sv
// zle_px: zero run-length encoder; nonzero values pass as literals, zero runs
// collapse into run-count tokens, with EOS flush and a runtime bypass mode.
module zle_px #(
    parameter int W      = 3,
    parameter int MAXRUN = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    input  logic         i_e,
    input  logic         i_v,
    output logic         i_b,
    output logic [W:0]   o_d,
    output logic         o_e,
    output logic         o_v,
    input  logic         o_b,
    input  logic         bypass
);
    localparam int CW = $clog2(MAXRUN + 1);

    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [W:0]    r_od, w_od_nx;
    logic          r_oe, r_ov, w_oe_nx, w_load;
    logic          w_free, w_nz, w_run, w_flush, w_eos, w_lit, w_zero, w_full;

    assign w_free  = !r_ov || !o_b;
    assign w_nz    = i_d != '0;
    assign w_run   = r_cnt != '0;
    assign w_flush = w_run && (bypass || (i_v && (i_e || w_nz)));
    assign w_eos   = i_v && i_e;
    assign w_lit   = i_v && !i_e && (w_nz || bypass);
    assign w_zero  = i_v && !i_e && !w_nz && !bypass;
    assign w_full  = r_cnt == CW'(MAXRUN - 1);

    always_comb begin
        i_b      = 1'b1;
        w_load   = 1'b0;
        w_od_nx  = '0;
        w_oe_nx  = 1'b0;
        w_cnt_nx = r_cnt;
        if (reset) begin
            i_b = 1'b1;
        end else if (w_zero && !w_full) begin
            // a growing run needs no output slot, so it proceeds even when stalled
            i_b      = 1'b0;
            w_cnt_nx = r_cnt + 1'b1;
        end else if (w_free) begin
            if (w_flush) begin
                w_load   = 1'b1;
                w_od_nx  = {1'b1, W'(r_cnt)};
                w_cnt_nx = '0;
            end else if (w_eos) begin
                i_b     = 1'b0;
                w_load  = 1'b1;
                w_oe_nx = 1'b1;
            end else if (w_lit) begin
                i_b     = 1'b0;
                w_load  = 1'b1;
                w_od_nx = {1'b0, i_d};
            end else if (w_zero) begin
                i_b      = 1'b0;
                w_load   = 1'b1;
                w_od_nx  = {1'b1, W'(MAXRUN)};
                w_cnt_nx = '0;
            end else begin
                i_b = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_od  <= '0;
            r_oe  <= 1'b0;
            r_ov  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            if (w_free) begin
                r_ov <= w_load;
                if (w_load) begin
                    r_od <= w_od_nx;
                    r_oe <= w_oe_nx;
                end
            end
        end
    end

    assign o_d = r_od;
    assign o_e = r_oe;
    assign o_v = r_ov;
endmodule

// File: tb/tb_zle_px.sv
// tb_zle_px: vector table plus hand sequences for zle_px, checked through an
// expected-token queue that the output monitor drains.
module tb_zle_px;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] i_d = '0;
    logic       i_e = 1'b0;
    logic       i_v = 1'b0;
    logic       i_b;
    logic [3:0] o_d;
    logic       o_e;
    logic       o_v;
    logic       o_b = 1'b0;
    logic       bypass = 1'b0;

    int total = 0;
    int bad = 0;
    logic [4:0] q[$];

    zle_px #(.W(3), .MAXRUN(7)) dut (
        .clock(clock), .reset(reset), .i_d(i_d), .i_e(i_e), .i_v(i_v), .i_b(i_b),
        .o_d(o_d), .o_e(o_e), .o_v(o_v), .o_b(o_b), .bypass(bypass)
    );

    always #5 clock = ~clock;

    // token format {eos, flag, value}
    typedef struct {
        logic [2:0] d;
        logic       e;
        logic       byp;
        int         stall;
        int         n;
        logic [4:0] x0;
        logic [4:0] x1;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // present one token until accepted; returns number of cycles it was held off
    task automatic send(input logic [2:0] d, input logic e, output int st);
        logic done;
        st = 0;
        done = 1'b0;
        i_v = 1'b1;
        i_d = d;
        i_e = e;
        while (!done && st < 40) begin
            @(negedge clock);
            if (!i_b) done = 1'b1;
            else st++;
        end
        @(posedge clock);
        #1;
        i_v = 1'b0;
        if (!done) chk("send_timeout", 32'(st), 32'd0);
    endtask

    always @(negedge clock) begin
        if (!reset && o_v && !o_b) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_token got=%0h want=none", {o_e, o_d});
            end else begin
                logic [4:0] x;
                x = q.pop_front();
                if ({o_e, o_d} !== x) begin
                    bad++;
                    $display("FAIL token got=%0h want=%0h at %0t", {o_e, o_d}, x, $time);
                end
            end
        end
    end

    initial begin
        int st;
        // 5,0,0,3
        tv.push_back('{3'd5, 1'b0, 1'b0, 0, 1, 5'h05, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd3, 1'b0, 1'b0, 1, 2, 5'h0A, 5'h03});
        // nine zeros then 1
        for (int i = 0; i < 9; i++)
            tv.push_back('{3'd0, 1'b0, 1'b0, 0, (i == 6) ? 1 : 0, 5'h0F, 5'h00});
        tv.push_back('{3'd1, 1'b0, 1'b0, 1, 2, 5'h0A, 5'h01});
        // 0,0,EOS then bare EOS
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd6, 1'b1, 1'b0, 1, 2, 5'h0A, 5'h10});
        tv.push_back('{3'd5, 1'b1, 1'b0, 0, 1, 5'h10, 5'h00});
        // bypass 0,0,4
        tv.push_back('{3'd0, 1'b0, 1'b1, 0, 1, 5'h00, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b1, 0, 1, 5'h00, 5'h00});
        tv.push_back('{3'd4, 1'b0, 1'b1, 0, 1, 5'h04, 5'h00});
        // run of 3 flushed by bypass rising together with a valid input
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd0, 1'b0, 1'b0, 0, 0, 5'h00, 5'h00});
        tv.push_back('{3'd2, 1'b0, 1'b1, 1, 2, 5'h0B, 5'h02});
        tv.push_back('{3'd1, 1'b0, 1'b0, 0, 1, 5'h01, 5'h00});

        @(negedge clock);
        chk("rst_o_v", 32'(o_v), 32'd0);
        chk("rst_o_e", 32'(o_e), 32'd0);
        chk("rst_o_d", 32'(o_d), 32'd0);
        chk("rst_i_b", 32'(i_b), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;

        foreach (tv[i]) begin
            bypass = tv[i].byp;
            if (tv[i].n > 0) q.push_back(tv[i].x0);
            if (tv[i].n > 1) q.push_back(tv[i].x1);
            send(tv[i].d, tv[i].e, st);
            chk($sformatf("stall_v%0d", i), 32'(st), 32'(tv[i].stall));
        end
        bypass = 1'b0;

        // back-pressure: held {0,4}, zeros still accepted, 6 blocked
        q.push_back(5'h04);
        send(3'd4, 1'b0, st);
        chk("bp_lat_v", 32'(o_v), 32'd1);
        chk("bp_lat_d", 32'(o_d), 32'h4);
        o_b = 1'b1;
        i_v = 1'b1;
        i_d = 3'd6;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("bp_ib6", 32'(i_b), 32'd1);
            chk("bp_hold", 32'({o_v, o_d}), 32'h14);
        end
        @(posedge clock);
        #1 i_v = 1'b0;
        send(3'd0, 1'b0, st);
        chk("bp_zero_stall", 32'(st), 32'd0);
        send(3'd0, 1'b0, st);
        chk("bp_zero_stall", 32'(st), 32'd0);
        i_v = 1'b1;
        i_d = 3'd6;
        @(negedge clock);
        chk("bp_ib6b", 32'(i_b), 32'd1);
        chk("bp_hold2", 32'({o_v, o_d}), 32'h14);
        @(posedge clock);
        #1 o_b = 1'b0;
        q.push_back(5'h0A);
        q.push_back(5'h06);
        send(3'd6, 1'b0, st);
        chk("bp_flush_stall", 32'(st), 32'd1);

        // asynchronous reset with pending run and held output
        q.push_back(5'h07);
        send(3'd7, 1'b0, st);
        o_b = 1'b1;
        for (int k = 0; k < 4; k++) send(3'd0, 1'b0, st);
        #3 reset = 1'b1;
        #1;
        chk("arst_o_v", 32'(o_v), 32'd0);
        chk("arst_o_d", 32'(o_d), 32'd0);
        chk("arst_i_b", 32'(i_b), 32'd1);
        q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        o_b = 1'b0;
        q.push_back(5'h02);
        send(3'd2, 1'b0, st);
        chk("arst_stall", 32'(st), 32'd0);

        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clock);
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
